pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core. It drives the enable and synchronous-clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, control redirects and multi-cycle data-memory waits. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: resolves memory waits, EX redirects
// and load-use hazards, and keeps stall/flush counters plus a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  // state    | meaning
  // RUN      | no data-memory wait in progress
  // MEM_WAIT | MEM stage waiting on dmem_ready; wait_cnt counts waited cycles
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        memwait, loaduse, redirect_take;

  assign memwait = mem_req & ~dmem_ready;
  assign loaduse = ex_mem_read & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign redirect_take = ex_redirect & ~memwait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // flag rises on the same edge the wait count reaches TIMEOUT
      if (wait_nxt == TO) mem_timeout <= 1'b1;
      if (!pc_en) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_take) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          if (wait_cnt < TO) wait_nxt = wait_cnt + 16'd1;
        end else begin
          state_nxt = RUN;
          wait_nxt  = 16'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 16'd0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (memwait) begin
      // hold PC..EX/MEM, push a bubble into WB; a pending redirect re-presents later
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (loaduse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
    logic        mt;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   vec_idx = 0;

  localparam logic [8:0] C_RST  = 9'b00000_1111;
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_RD   = 9'b11111_1100;
  localparam logic [8:0] C_MW   = 9'b00001_0001;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                      input logic rdr, input logic mq, input logic dr,
                      input logic [8:0] ctrl, input int st, input int fl, input logic mt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_rd = rd; ex_redirect = rdr; mem_req = mq; dmem_ready = dr;
    e.ctrl = ctrl; e.stall = st; e.flush = fl; e.mt = mt;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
      n_total++;
      if (act === e.ctrl && stall_cnt === e.stall && flush_cnt === e.flush &&
          mem_timeout === e.mt)
        n_pass++;
      else
        $display("FAIL vec%0d: ctrl=%b stall=%0d flush=%0d mt=%b, required ctrl=%b stall=%0d flush=%0d mt=%b",
                 vec_idx, act, stall_cnt, flush_cnt, mem_timeout,
                 e.ctrl, e.stall, e.flush, e.mt);
      vec_idx++;
    end
  end

  initial begin
    reset = 1'b0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 0;
    //   rst rs1 rs2 u1 u2 mr rd rdr mq dr  ctrl    st fl mt
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);
    // load-use through rs2
    step(1, 0, 5, 0, 1, 1, 5, 0, 0, 0, C_LU,   0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 0, 0);
    // x0 destination, then rs2 not used: no stall
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, C_NORM, 1, 0, 0);
    step(1, 0, 5, 0, 0, 1, 5, 0, 0, 0, C_NORM, 1, 0, 0);
    // redirect beats load-use
    step(1, 0, 5, 0, 1, 1, 5, 1, 0, 0, C_RD,   1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1, 1, 0);
    // 4-cycle memory wait with redirect pending; timeout (4) reached on 4th wait edge
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   2, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   3, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   4, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_RD,   5, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 5, 2, 1);
    // reset clears counters and flag
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);
    // 6-cycle wait: flag rises after 4th wait cycle, saturates, stays sticky
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   4, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   5, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NORM, 6, 0, 1);
    // second wait aborted by reset mid-wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   6, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   7, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,  0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0, 0);
    // load-use through rs1, then matching register with non-load in EX
    step(1, 7, 0, 1, 0, 1, 7, 0, 0, 0, C_LU,   0, 0, 0);
    step(1, 7, 0, 1, 0, 0, 7, 0, 0, 0, C_NORM, 1, 0, 0);
    // mem_req dropping in the middle of a wait releases it
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RD,   2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 2, 1, 0);
    repeat (3) @(posedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
